// File: rtl/checkbits_tx.sv
// checkbits_tx: FIFO-fed checkbits status transmitter with hold/gap timing (CHECKBITS_TX_LOCK_EN adds terminal-code lock)
module checkbits_tx #(
  parameter int DEPTH = 8,
  parameter int HOLD_CYCLES = 64,
  parameter int GAP_CYCLES = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     push_i,
  input  logic [6:0]               code_i,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
  output logic                     drop_o,
  output logic [6:0]               io_out,
  output logic [6:0]               io_oeb
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state;
  logic [6:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic avail, accept, pop, store, flush;
  assign ready_o = level_o != LW'(DEPTH);
  assign busy_o = state != IDLE || level_o != '0;
  assign accept = push_i && ready_o;
  assign pop = state == IDLE && avail && level_o != '0;
  assign store = accept && code_i != '0 && !flush;
`ifdef CHECKBITS_TX_LOCK_EN
  logic locked, terminal;
  assign terminal = mem[rd_ptr] == 7'h02 || mem[rd_ptr] == 7'h7f;
  assign flush = locked || (pop && terminal);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) locked <= 1'b0;
    else if (pop && terminal) locked <= 1'b1;
  end
`else
  assign flush = 1'b0;
`endif
  always_ff @(posedge wb_clk_i) begin
    if (store) mem[wr_ptr] <= code_i;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
      avail <= 1'b0;
      drop_o <= 1'b0;
      io_oeb <= 7'h7f;
    end else begin
      wr_ptr <= store ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= flush ? wr_ptr : pop ? rd_ptr + 1'b1 : rd_ptr;
      level_o <= flush ? '0 : level_o + LW'(store) - LW'(pop);
      avail <= level_o != '0;
      drop_o <= accept && !store;
      io_oeb <= '0;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      io_out <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          io_out <= mem[rd_ptr];
          cnt <= CW'(HOLD_CYCLES - 1);
          state <= HOLD;
        end
        HOLD: if (cnt == '0) begin
          io_out <= '0;
          cnt <= CW'(GAP_CYCLES - 1);
          state <= GAP;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_checkbits_tx.sv
// tb_checkbits_tx: directed self-checking bench for checkbits_tx (DEPTH=8, HOLD=4, GAP=2)
module tb_checkbits_tx;
  logic clk = 1'b0, rst = 1'b1, push = 1'b0;
  logic [6:0] code = '0;
  logic ready, busy, drop;
  logic [3:0] level;
  logic [6:0] io_out, io_oeb;
  int passed = 0, total = 0, fails = 0, drops = 0;
  logic [6:0] seen [$];
  logic [6:0] prev = '0;
  logic [6:0] cap [16];
  logic cap_b [16];
  logic [6:0] exp_w [16];
  logic [3:0] exp_lvl [12];
  checkbits_tx #(.DEPTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .push_i(push), .code_i(code), .ready_o(ready),
    .level_o(level), .busy_o(busy), .drop_o(drop), .io_out(io_out), .io_oeb(io_oeb)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (io_out !== prev && io_out != '0) seen.push_back(io_out);
    prev = io_out;
    if (drop === 1'b1) drops++;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] seen_at(input int i);
    return i < seen.size() ? 32'(seen[i]) : 32'hffff;
  endfunction
  task automatic cmp_cap(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", tag, i), 32'(cap[i]), 32'(exp_w[i]));
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_io_out", 32'(io_out), 0);
    chk("rst_io_oeb", 32'(io_oeb), 32'h7f);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop), 0);
    rst = 1'b0;
    tick();
    chk("oeb_release", 32'(io_oeb), 0);
    push = 1'b1; code = 7'h01;
    tick();
    push = 1'b0;
    chk("single_level", 32'(level), 1);
    chk("single_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin tick(); cap[i] = io_out; cap_b[i] = busy; end
    exp_w = '{7'h00, 7'h01, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00, 7'h00,
              7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    cmp_cap("single_bus");
    chk("single_busy_gap", 32'(cap_b[6]), 1);
    chk("single_busy_done", 32'(cap_b[7]), 0);
    seen.delete();
    push = 1'b1; code = 7'h41;
    tick();
    tick();
    push = 1'b0;
    for (int i = 0; i < 16; i++) begin tick(); cap[i] = io_out; end
    exp_w = '{7'h41, 7'h41, 7'h41, 7'h41, 7'h00, 7'h00, 7'h00, 7'h41,
              7'h41, 7'h41, 7'h41, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    cmp_cap("b2b_bus");
    chk("b2b_seen_n", seen.size(), 2);
    push = 1'b1; code = 7'h00;
    tick();
    push = 1'b0;
    chk("zero_drop", 32'(drop), 1);
    chk("zero_level", 32'(level), 0);
    chk("zero_io", 32'(io_out), 0);
    tick();
    chk("zero_drop_end", 32'(drop), 0);
    chk("zero_io2", 32'(io_out), 0);
    seen.delete();
    push = 1'b1; code = 7'h2f;
    tick();
    push = 1'b0;
    tick();
    tick();
    chk("pre_code", 32'(io_out), 32'h2f);
    exp_lvl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8};
    push = 1'b1;
    for (int i = 0; i < 12; i++) begin
      code = 7'(7'h30 + i);
      tick();
      chk($sformatf("full_level[%0d]", i), 32'(level), 32'(exp_lvl[i]));
    end
    push = 1'b0;
    chk("full_ready", 32'(ready), 0);
    repeat (60) tick();
    chk("full_busy_end", 32'(busy), 0);
    chk("full_seen_n", seen.size(), 10);
    chk("full_seen_pre", seen_at(0), 32'h2f);
    for (int i = 0; i < 9; i++) chk($sformatf("full_order[%0d]", i), seen_at(i + 1), 32'(7'h30 + i));
    seen.delete();
    push = 1'b1; code = 7'h44;
    tick();
    code = 7'h45;
    tick();
    push = 1'b0;
    tick();
    tick();
    chk("mid_hold_io", 32'(io_out), 32'h44);
    chk("mid_hold_level", 32'(level), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_io", 32'(io_out), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_oeb", 32'(io_oeb), 32'h7f);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    chk("mid_oeb_release", 32'(io_oeb), 0);
    repeat (15) tick();
    chk("mid_seen_n", seen.size(), 1);
    chk("mid_seen_0", seen_at(0), 32'h44);
    seen.delete();
    drops = 0;
    push = 1'b1; code = 7'h02;
    tick();
    push = 1'b0;
    tick();
    tick();
    chk("term_io", 32'(io_out), 32'h02);
    push = 1'b1; code = 7'h58;
    tick();
    push = 1'b0;
`ifdef CHECKBITS_TX_LOCK_EN
    chk("term_level", 32'(level), 0);
    chk("term_drop", 32'(drop), 1);
`else
    chk("term_level", 32'(level), 1);
    chk("term_drop", 32'(drop), 0);
`endif
    repeat (20) tick();
    chk("term_seen_0", seen_at(0), 32'h02);
`ifdef CHECKBITS_TX_LOCK_EN
    chk("term_seen_n", seen.size(), 1);
    chk("term_drops", drops, 1);
`else
    chk("term_seen_n", seen.size(), 2);
    chk("term_seen_1", seen_at(1), 32'h58);
    chk("term_drops", drops, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
